mux_rr_arbiter: RTL and testbench



---
 rtl/mux_rr_arbiter_pkg.sv | 7 +
 rtl/mux_rr_arbiter_rr_pick.sv | 20 ++
 rtl/mux_rr_arbiter.sv | 48 ++++
 tb/tb_mux_rr_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter_pkg: shared sizes and FSM state encoding for the round-robin arbiter
package mux_rr_arbiter_pkg;
  localparam int N_REQ = 8;
  localparam int SEL_W = 3;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_OWN  = 1'b1;
endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick: rotate requests by ptr, then pick the first set bit at or after ptr
module rr_pick
  import mux_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);
  logic [N_REQ-1:0] rot;
  logic [SEL_W-1:0] off;
  always_comb begin
    rot = N_REQ'({req, req} >> ptr);
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (rot[i]) off = SEL_W'(i);
  end
  assign idx = ptr + off;
  assign any = |req;
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner of the 8:1 mux select with a hold timer that forces rotation
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [N_REQ-1:0] Req,
  output logic [SEL_W-1:0] MuxSelect,
  output logic [N_REQ-1:0] Grant,
  output logic             Valid,
  output logic             Preempt
);
  logic [0:0]       state;
  logic [SEL_W-1:0] ptr, idx;
  logic [CNT_W-1:0] cnt;
  logic             any;
  rr_pick u_pick (.req(Req), .ptr(ptr), .idx(idx), .any(any));
  assign Valid = |Grant;
  // every release returns to IDLE, which yields the one-cycle dead gap between owners
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      state     <= S_IDLE;
      ptr       <= '0;
      cnt       <= '0;
      Grant     <= '0;
      MuxSelect <= '0;
      Preempt   <= 1'b0;
    end else begin
      Preempt <= 1'b0;
      if (state == S_IDLE) begin
        if (any) begin
          state     <= S_OWN;
          Grant     <= N_REQ'(1) << idx;
          MuxSelect <= idx;
          cnt       <= '0;
        end
      end else if (!Req[MuxSelect] || cnt == CNT_W'(MAX_HOLD - 1)) begin
        state   <= S_IDLE;
        Grant   <= '0;
        ptr     <= MuxSelect + SEL_W'(1);
        Preempt <= Req[MuxSelect];
      end else
        cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed table, corner sequences and random traffic against an owner/tenure model
module tb_mux_rr_arbiter;
  logic       Clock = 1'b0, Resetn = 1'b0;
  logic [7:0] Req = '0;
  logic [7:0] ga, gb;
  logic [2:0] sa, sb;
  logic       va, vb, pa, pb;

  mux_rr_arbiter #(.MAX_HOLD(16), .CNT_W(8)) dut_a (
    .Clock(Clock), .Resetn(Resetn), .Req(Req),
    .MuxSelect(sa), .Grant(ga), .Valid(va), .Preempt(pa));
  mux_rr_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut_b (
    .Clock(Clock), .Resetn(Resetn), .Req(Req),
    .MuxSelect(sb), .Grant(gb), .Valid(vb), .Preempt(pb));

  always #5 Clock = ~Clock;

  int n_vec = 0, n_bad = 0;
  int m_own[2], m_held[2], m_ptr[2], m_sel[2], m_pre[2];
  int mh[2] = '{16, 4};

  typedef struct {
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       pre;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_own[i] = -1; m_held[i] = 0; m_ptr[i] = 0; m_sel[i] = 0; m_pre[i] = 0;
    end
  endtask

  // owner -1 means no grant; held counts granted cycles so far in this tenure
  task automatic model_step(input logic [7:0] r);
    for (int i = 0; i < 2; i++) begin
      m_pre[i] = 0;
      if (m_own[i] < 0) begin
        for (int j = 0; j < 8; j++)
          if (m_own[i] < 0 && r[(m_ptr[i] + j) % 8]) begin
            m_own[i] = (m_ptr[i] + j) % 8;
            m_sel[i] = m_own[i];
            m_held[i] = 1;
          end
      end else if (!r[m_own[i]] || m_held[i] == mh[i]) begin
        m_pre[i] = r[m_own[i]] ? 1 : 0;
        m_ptr[i] = (m_own[i] + 1) % 8;
        m_own[i] = -1;
      end else
        m_held[i]++;
    end
  endtask

  function automatic logic [31:0] exp_grant(input int i);
    return m_own[i] < 0 ? 32'd0 : 32'd1 << m_own[i];
  endfunction

  task automatic check_all();
    chk("grant_a", ga, exp_grant(0));
    chk("sel_a", sa, m_sel[0]);
    chk("valid_a", va, m_own[0] >= 0);
    chk("preempt_a", pa, m_pre[0]);
    chk("grant_b", gb, exp_grant(1));
    chk("sel_b", sb, m_sel[1]);
    chk("valid_b", vb, m_own[1] >= 0);
    chk("preempt_b", pb, m_pre[1]);
  endtask

  task automatic step(input logic [7:0] r);
    Req = r;
    @(posedge Clock);
    model_step(r);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    Req = '0;
    Resetn = 1'b0;
    #2;
    chk("rst_grant", {ga, gb}, 0);
    chk("rst_sel", {sa, sb}, 0);
    chk("rst_flags", {va, vb, pa, pb}, 0);
    model_reset();
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
  endtask

  logic [7:0] r;

  initial begin
    tbl[0] = '{8'h00, 8'h00, 3'd0, 1'b0};
    tbl[1] = '{8'h00, 8'h00, 3'd0, 1'b0};
    tbl[2] = '{8'h00, 8'h00, 3'd0, 1'b0};
    tbl[3] = '{8'h00, 8'h00, 3'd0, 1'b0};
    tbl[4] = '{8'h00, 8'h00, 3'd0, 1'b0};
    tbl[5] = '{8'h24, 8'h04, 3'd2, 1'b0};
    tbl[6] = '{8'h20, 8'h00, 3'd2, 1'b0};
    tbl[7] = '{8'h20, 8'h20, 3'd5, 1'b0};
    tbl[8] = '{8'h00, 8'h00, 3'd5, 1'b0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].req);
      chk("tbl_grant", ga, tbl[i].grant);
      chk("tbl_sel", sa, tbl[i].sel);
      chk("tbl_pre", pa, tbl[i].pre);
    end

    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(8'h01);
      chk("hold16_grant", ga, 8'h01);
    end
    step(8'h01);
    chk("hold16_gap", ga, 8'h00);
    chk("hold16_preempt", pa, 1'b1);
    step(8'h01);
    chk("hold16_rewin", ga, 8'h01);
    chk("hold16_pre_clear", pa, 1'b0);

    do_reset();
    for (int o = 0; o < 9; o++) begin
      for (int c = 0; c < 4; c++) begin
        step(8'hFF);
        chk("rr_grant", gb, 8'h01 << (o % 8));
        chk("rr_sel", sb, o % 8);
      end
      if (o < 8) begin
        step(8'hFF);
        chk("rr_gap", gb, 8'h00);
        chk("rr_preempt", pb, 1'b1);
      end
    end

    do_reset();
    step(8'h80);
    chk("wrap_own7", ga, 8'h80);
    step(8'h01);
    chk("wrap_release", ga, 8'h00);
    chk("wrap_no_preempt", pa, 1'b0);
    step(8'h01);
    chk("wrap_grant0", ga, 8'h01);
    chk("wrap_sel0", sa, 3'd0);

    do_reset();
    for (int i = 0; i < 4; i++) step(8'h08);
    chk("mid_grant", ga, 8'h08);
    #2;
    Resetn = 1'b0;
    #1;
    chk("async_grant", {ga, gb}, 0);
    chk("async_sel", {sa, sb}, 0);
    chk("async_flags", {va, vb, pa, pb}, 0);
    model_reset();
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
    step(8'h08);
    chk("restart_grant", ga, 8'h08);
    for (int i = 0; i < 16; i++) step(8'h08);
    chk("restart_full_tenure", pa, 1'b1);

    do_reset();
    r = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom);
      if ($urandom_range(0, 15) == 0) r = '0;
      step(r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
